// File: rtl/code_conv_pkg.sv
// code_conv_pkg: shared types and default widths for the code converter.
// Conversion mode encoding matches the 2-bit i_mode port of code_conv_pipe.
package code_conv_pkg;

  typedef enum logic [1:0] {
    CONV_U1_U2 = 2'd0,
    CONV_U2_U1 = 2'd1,
    CONV_ZM_U2 = 2'd2,
    CONV_U2_ZM = 2'd3
  } conv_mode_e;

  localparam int BITS_DEF  = 8;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/code_conv_core.sv
// code_conv_core: combinational mapping of one operand between U1, U2 and ZM.
// Non-negative operands pass through unchanged in every mode. Values that have
// no representation in the target code are saturated and flagged on o_ovf.
module code_conv_core
  import code_conv_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic [BITS-1:0] i_arg,
  input  conv_mode_e      i_mode,
  output logic [BITS-1:0] o_result,
  output logic            o_ovf
);

  localparam logic [BITS-1:0] MIN_VAL = {1'b1, {(BITS-1){1'b0}}};
  localparam logic [BITS-1:0] ONE     = BITS'(1);

  logic            w_sign;
  logic            w_is_min;
  logic [BITS-1:0] w_neg;
  logic [BITS-1:0] w_mag_zm;

  assign w_sign   = i_arg[BITS-1];
  assign w_is_min = (i_arg == MIN_VAL);
  assign w_neg    = ~i_arg + ONE;
  assign w_mag_zm = {1'b0, i_arg[BITS-2:0]};

  // Select the conversion for negative operands; positive ones fall through.
  always_comb begin
    o_result = i_arg;
    o_ovf    = 1'b0;
    if (w_sign) begin
      case (i_mode)
        CONV_U1_U2: o_result = i_arg + ONE;
        CONV_U2_U1: begin
          if (w_is_min) begin
            o_result = MIN_VAL;
            o_ovf    = 1'b1;
          end else begin
            o_result = i_arg - ONE;
          end
        end
        CONV_ZM_U2: o_result = ~w_mag_zm + ONE;
        CONV_U2_ZM: begin
          if (w_is_min) begin
            o_result = '1;
            o_ovf    = 1'b1;
          end else begin
            o_result = {1'b1, w_neg[BITS-2:0]};
          end
        end
        default: o_result = i_arg;
      endcase
    end
  end

endmodule

// File: rtl/code_conv_pipe.sv
// code_conv_pipe: two-stage valid/ready pipeline around code_conv_core.
// S1 registers the operand and mode, the core converts from S1, S2 registers
// the result. Optional statistics counters are enabled by CODE_CONV_STATS_EN.
module code_conv_pipe
  import code_conv_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [BITS-1:0]  i_argA,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BITS-1:0]  o_result,
  output logic             o_ovf
`ifdef CODE_CONV_STATS_EN
  ,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt_conv,
  output logic [CNT_W-1:0] o_cnt_ovf
`endif
);

  if (BITS < 2 || BITS > 32 || CNT_W < 1) begin : g_param_chk
    $error("code_conv_pipe: BITS must be 2..32 and CNT_W at least 1");
  end

  logic            w_s2_load;
  logic            w_s1_load;
  logic            r_s1_v;
  logic            r_s2_v;
  logic [BITS-1:0] r_s1_arg;
  logic [1:0]      r_s1_mode;
  logic [BITS-1:0] w_core_res;
  logic            w_core_ovf;
  logic [BITS-1:0] r_s2_res;
  logic            r_s2_ovf;

  // S2 may advance whenever it is empty or its word is being taken; S1 may
  // advance whenever it is empty or can hand its word to S2.
  assign w_s2_load = !r_s2_v || i_ready;
  assign w_s1_load = !r_s1_v || w_s2_load;
  assign o_ready   = w_s1_load;
  assign o_valid   = r_s2_v;
  assign o_result  = r_s2_res;
  assign o_ovf     = r_s2_ovf;

  // S1: capture operand and mode on input transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_arg  <= '0;
      r_s1_mode <= '0;
    end else if (w_s1_load) begin
      r_s1_v <= i_valid;
      if (i_valid) begin
        r_s1_arg  <= i_argA;
        r_s1_mode <= i_mode;
      end
    end
  end

  code_conv_core #(
    .BITS (BITS)
  ) u_core (
    .i_arg    (r_s1_arg),
    .i_mode   (conv_mode_e'(r_s1_mode)),
    .o_result (w_core_res),
    .o_ovf    (w_core_ovf)
  );

  // S2: hold converted result; frozen while downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_v   <= 1'b0;
      r_s2_res <= '0;
      r_s2_ovf <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_res <= w_core_res;
        r_s2_ovf <= w_core_ovf;
      end
    end
  end

`ifdef CODE_CONV_STATS_EN
  logic             w_out_xfer;
  logic [CNT_W-1:0] r_cnt_conv;
  logic [CNT_W-1:0] r_cnt_ovf;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_out_xfer = r_s2_v && i_ready;
  assign o_cnt_conv = r_cnt_conv;
  assign o_cnt_ovf  = r_cnt_ovf;

  // Saturating delivery counters; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_conv <= '0;
      r_cnt_ovf  <= '0;
    end else if (i_clr) begin
      r_cnt_conv <= '0;
      r_cnt_ovf  <= '0;
    end else if (w_out_xfer) begin
      r_cnt_conv <= sat_inc(r_cnt_conv);
      if (r_s2_ovf) begin
        r_cnt_ovf <= sat_inc(r_cnt_ovf);
      end
    end
  end
`endif

endmodule

// File: tb/tb_code_conv_pipe.sv
// tb_code_conv_pipe: directed and randomized checks of code_conv_pipe (BITS=8).
// Expected results come from a value-level model: decode the source code to an
// integer, then encode it in the target code with a range check.
module tb_code_conv_pipe;

  localparam int BITS  = 8;
  localparam int CNT_W = 3;

  logic             clk;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [BITS-1:0]  i_argA;
  logic [1:0]       i_mode;
  logic             o_valid;
  logic             i_ready;
  logic [BITS-1:0]  o_result;
  logic             o_ovf;
`ifdef CODE_CONV_STATS_EN
  logic             i_clr;
  logic [CNT_W-1:0] o_cnt_conv;
  logic [CNT_W-1:0] o_cnt_ovf;
`endif

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  code_conv_pipe #(
    .BITS  (BITS),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_argA     (i_argA),
    .i_mode     (i_mode),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_ovf      (o_ovf)
`ifdef CODE_CONV_STATS_EN
    ,
    .i_clr      (i_clr),
    .o_cnt_conv (o_cnt_conv),
    .o_cnt_ovf  (o_cnt_ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, result} for an 8-bit operand.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [1:0] m);
    int ai;
    int v;
    int t;
    logic o;
    ai = int'(a);
    o  = 1'b0;
    case (m)
      2'd0:    v = (ai >= 128) ? ai - 255 : ai;
      2'd2:    v = (ai >= 128) ? -(ai - 128) : ai;
      default: v = (ai >= 128) ? ai - 256 : ai;
    endcase
    case (m)
      2'd1: begin
        if (v < -127) begin o = 1'b1; t = 128; end
        else t = (v >= 0) ? v : 255 + v;
      end
      2'd3: begin
        if (v < -127) begin o = 1'b1; t = 255; end
        else t = (v >= 0) ? v : 128 - v;
      end
      default: t = v;
    endcase
    return {o, t[7:0]};
  endfunction

  // One clock: drive inputs, score any output transfer, record any input transfer.
  task automatic step(input logic v, input logic [7:0] a, input logic [1:0] m, input logic r);
    logic [8:0] e;
    i_valid = v;
    i_argA  = a;
    i_mode  = m;
    i_ready = r;
    #1;
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 32'(o_result), 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        chk("stream_res", 32'({o_ovf, o_result}), 32'(e));
      end
    end
    if (v && o_ready) exp_q.push_back(model(a, m));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(1'b0, 8'h00, 2'd0, 1'b1);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Single word with i_ready high: check latency and value against a constant.
  task automatic single(input logic [7:0] a, input logic [1:0] m,
                        input logic [7:0] er, input logic eo, input string tag);
    i_valid = 1'b1;
    i_argA  = a;
    i_mode  = m;
    i_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_argA  = 8'($urandom);
    i_mode  = 2'($urandom);
    chk({tag, "_lat1"}, 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_lat2"}, 32'(o_valid), 32'd1);
    chk({tag, "_res"}, 32'(o_result), 32'(er));
    chk({tag, "_ovf"}, 32'(o_ovf), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] held;
    logic       rv;
    logic       rr;
    logic [7:0] ra;
    i_rst_n = 1'b1;
    i_valid = 1'b0;
    i_argA  = '0;
    i_mode  = '0;
    i_ready = 1'b0;
`ifdef CODE_CONV_STATS_EN
    i_clr   = 1'b0;
`endif
    #2 i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_ovf", 32'(o_ovf), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);

    single(8'hFE, 2'd0, 8'hFF, 1'b0, "u1u2_fe");
    single(8'hFF, 2'd0, 8'h00, 1'b0, "u1u2_ff");
    single(8'h05, 2'd0, 8'h05, 1'b0, "u1u2_05");
    single(8'hFF, 2'd1, 8'hFE, 1'b0, "u2u1_ff");
    single(8'h80, 2'd1, 8'h80, 1'b1, "u2u1_min");
    single(8'h7F, 2'd1, 8'h7F, 1'b0, "u2u1_7f");
    single(8'h85, 2'd2, 8'hFB, 1'b0, "zmu2_85");
    single(8'h80, 2'd2, 8'h00, 1'b0, "zmu2_min");
    single(8'hFB, 2'd3, 8'h85, 1'b0, "u2zm_fb");
    single(8'h80, 2'd3, 8'hFF, 1'b1, "u2zm_min");

    // Backpressure: two words in, then downstream stalls for three cycles.
    step(1'b1, 8'h01, 2'd0, 1'b1);
    step(1'b1, 8'h02, 2'd0, 1'b1);
    i_valid = 1'b1;
    i_argA  = 8'h03;
    i_ready = 1'b0;
    #1;
    chk("bp_full_rdy", 32'(o_ready), 32'd0);
    chk("bp_full_vld", 32'(o_valid), 32'd1);
    held = o_result;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_res", 32'(o_result), 32'(held));
      chk("bp_hold_rdy", 32'(o_ready), 32'd0);
    end
    for (int w = 3; w <= 6; w++) step(1'b1, 8'(w), 2'd0, 1'b1);
    drain("bp_drain");

    // Full-rate burst: ready must stay high with downstream always accepting.
    for (int k = 0; k < 8; k++) begin
      chk("thru_rdy", 32'(o_ready), 32'd1);
      step(1'b1, 8'($urandom), 2'($urandom), 1'b1);
    end
    drain("thru_drain");

    // Random traffic with random stalls on both sides.
    for (int k = 0; k < 300; k++) begin
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      step(rv, ra, 2'($urandom), rr);
    end
    drain("rand_drain");

    // Reset with two words in flight.
    step(1'b1, 8'h11, 2'd0, 1'b0);
    step(1'b1, 8'h22, 2'd0, 1'b0);
    chk("mid_inflight", 32'(o_valid), 32'd1);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk("mid_no_out", 32'(o_valid), 32'd0);
      step(1'b0, 8'h00, 2'd0, 1'b1);
    end

`ifdef CODE_CONV_STATS_EN
    chk("cnt_rst_conv", 32'(o_cnt_conv), 32'd0);
    chk("cnt_rst_ovf", 32'(o_cnt_ovf), 32'd0);
    step(1'b1, 8'h80, 2'd1, 1'b1);
    step(1'b1, 8'h10, 2'd0, 1'b1);
    step(1'b1, 8'h80, 2'd3, 1'b1);
    step(1'b1, 8'hFE, 2'd0, 1'b1);
    step(1'b1, 8'h85, 2'd2, 1'b1);
    drain("cnt_drain");
    chk("cnt_conv5", 32'(o_cnt_conv), 32'd5);
    chk("cnt_ovf2", 32'(o_cnt_ovf), 32'd2);
    for (int k = 0; k < 3; k++) step(1'b1, 8'(k), 2'd0, 1'b1);
    drain("cnt_sat_drain");
    chk("cnt_conv_sat", 32'(o_cnt_conv), 32'd7);
    chk("cnt_ovf_keep", 32'(o_cnt_ovf), 32'd2);
    step(1'b1, 8'h80, 2'd1, 1'b1);
    step(1'b0, 8'h00, 2'd0, 1'b1);
    chk("clr_pending", 32'(o_valid), 32'd1);
    i_clr = 1'b1;
    step(1'b0, 8'h00, 2'd0, 1'b1);
    i_clr = 1'b0;
    chk("clr_conv", 32'(o_cnt_conv), 32'd0);
    chk("clr_ovf", 32'(o_cnt_ovf), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
